switch_debounce_filter: RTL and testbench



---
 rtl/switch_debounce_filter.sv | 142 ++++++++++++++
 tb/tb_switch_debounce_filter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce_filter.sv
`default_nettype none
// ============================================================================
// switch_debounce_filter
// Per-bit debouncer: 2-flop synchronizer, shared tick prescaler, per-bit
// stability counters, registered level plus rise/fall/changed strobes.
// Optional: SWITCH_DEBOUNCE_STICKY_EN adds sticky_clr / sticky event flags.
// Revision: 1.0
// ============================================================================
module switch_debounce_filter #(
    parameter int               WIDTH        = 16,
    parameter int               TICK_DIV     = 1000,
    parameter int               STABLE_TICKS = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switch,
`ifdef SWITCH_DEBOUNCE_STICKY_EN
    input  logic [WIDTH-1:0] sticky_clr,
    output logic [WIDTH-1:0] sticky,
`endif
    output logic [WIDTH-1:0] switch_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             tick
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int               STB_W    = $clog2(STABLE_TICKS) + 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_TICKS - 1);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             tick_q;
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] accept;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             changed_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= switch;
            sync_q <= meta_q;
        end
    end

    always_comb begin
        pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
    end

    // tick is registered from the terminal count, so it lands TICK_DIV cycles after release
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= (pre_q == PRE_LAST);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic [STB_W-1:0] cnt_q;
        logic [STB_W-1:0] cnt_d;
        logic             acc;

        // Any agreement with the current level restarts qualification
        always_comb begin
            cnt_d = cnt_q;
            acc   = 1'b0;
            if (sync_q[i] == db_q[i]) begin
                cnt_d = '0;
            end else if (tick_q) begin
                if (cnt_q == STB_LAST) begin
                    acc   = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + STB_W'(1);
                end
            end
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign accept[i] = acc;
    end

    // An accepted bit is by definition mismatched, so accepting toggles it
    assign db_d = db_q ^ accept;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_q      <= RESET_VALUE;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            db_q      <= db_d;
            rise_q    <= accept & sync_q;
            fall_q    <= accept & ~sync_q;
            changed_q <= |accept;
        end
    end

`ifdef SWITCH_DEBOUNCE_STICKY_EN
    logic [WIDTH-1:0] sticky_q;

    // Set has priority over clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (sticky_q & ~sticky_clr) | rise_q | fall_q;
        end
    end

    assign sticky = sticky_q;
`endif

    assign switch_db = db_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign changed   = changed_q;
    assign tick      = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce_filter.sv
`default_nettype none
// ============================================================================
// tb_switch_debounce_filter
// Directed and random stimulus against a tick-counting reference model.
// Revision: 1.0
// ============================================================================
module tb_switch_debounce_filter;

    localparam int W = 4;
    localparam int D = 4;
    localparam int S = 3;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic [W-1:0] switch = '0;
    logic [W-1:0] switch_db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         tick;
`ifdef SWITCH_DEBOUNCE_STICKY_EN
    logic [W-1:0] sticky_clr = '0;
    logic [W-1:0] sticky;
    logic [W-1:0] m_sticky;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: n counts cycles since reset release
    int           n;
    int           start [W];
    logic [W-1:0] p1, p2;
    logic [W-1:0] m_db, m_rise, m_fall;
    logic         m_changed;
    logic [W-1:0] obs_db, obs_rise;
    logic         obs_changed;

    always #5 clock = ~clock;

    switch_debounce_filter #(
        .WIDTH        (W),
        .TICK_DIV     (D),
        .STABLE_TICKS (S),
        .RESET_VALUE  (4'b0000)
    ) u_dut (
        .clock      (clock),
        .reset      (reset),
        .switch     (switch),
`ifdef SWITCH_DEBOUNCE_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky     (sticky),
`endif
        .switch_db  (switch_db),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed),
        .tick       (tick)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Number of tick cycles in [0, x]; ticks fall on cycles D, 2D, ...
    function automatic int ticks_upto(input int x);
        return (x < D) ? 0 : x / D;
    endfunction

    task automatic model_reset();
        n         = 0;
        p1        = '0;
        p2        = '0;
        m_db      = '0;
        m_rise    = '0;
        m_fall    = '0;
        m_changed = 1'b0;
        for (int b = 0; b < W; b++) start[b] = -1;
`ifdef SWITCH_DEBOUNCE_STICKY_EN
        m_sticky  = '0;
`endif
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic run_cycle(input logic [W-1:0] sw);
        logic [W-1:0] sync;
        logic [W-1:0] acc;
        switch = sw;
        @(negedge clock);
        chk("db", 32'(switch_db), 32'(m_db));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("changed", 32'(changed), 32'(m_changed));
        chk("tick", 32'(tick), 32'((n >= D) && (n % D == 0)));
`ifdef SWITCH_DEBOUNCE_STICKY_EN
        chk("sticky", 32'(sticky), 32'(m_sticky));
`endif
        obs_db      = switch_db;
        obs_rise    = rise;
        obs_changed = changed;

        sync = p2;
        acc  = '0;
        for (int b = 0; b < W; b++) begin
            if (sync[b] != m_db[b]) begin
                if (start[b] < 0) start[b] = n;
                if (ticks_upto(n) - ticks_upto(start[b] - 1) == S) begin
                    acc[b]   = 1'b1;
                    start[b] = -1;
                end
            end else begin
                start[b] = -1;
            end
        end
`ifdef SWITCH_DEBOUNCE_STICKY_EN
        m_sticky = (m_sticky & ~sticky_clr) | m_rise | m_fall;
`endif
        m_db      = m_db ^ acc;
        m_rise    = acc & sync;
        m_fall    = acc & ~sync;
        m_changed = |acc;
        p2 = p1;
        p1 = sw;
        n++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic [W-1:0] sw);
        switch = sw;
        reset  = 1'b1;
        #1;
        chk("rst_db", 32'(switch_db), 32'h0);
        chk("rst_evt", 32'({rise, fall}), 32'h0);
        chk("rst_chg", 32'(changed), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
`ifdef SWITCH_DEBOUNCE_STICKY_EN
        chk("rst_sticky", 32'(sticky), 32'h0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int           lat;
        int           cnt;
        logic [W-1:0] cap;
        logic [W-1:0] sw;

        #2;
        do_reset(4'b0000);

        repeat (100) run_cycle(4'b0000);

        // Single step on bit 0
        lat = -1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b0001);
            if (lat < 0 && obs_db[0]) lat = k;
            if (obs_rise[0]) cnt++;
        end
        chk("lat_step", 32'(lat >= 11 && lat <= 14), 32'h1);
        chk("rise_once", 32'(cnt), 32'h1);

        // Short pulses on bit 1 never qualify
        cnt = 0;
        repeat (5) begin
            for (int k = 0; k < 8; k++) begin
                run_cycle(4'b0011);
                if (obs_changed) cnt++;
            end
            for (int k = 0; k < 12; k++) begin
                run_cycle(4'b0001);
                if (obs_changed) cnt++;
            end
        end
        chk("bounce_db1", 32'(obs_db[1]), 32'h0);
        chk("bounce_evt", 32'(cnt), 32'h0);

        // Two bits stepping together
        cnt = 0;
        cap = '0;
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b1101);
            if (obs_changed) begin
                cnt++;
                cap = obs_rise;
            end
        end
        chk("rise_pair", 32'(cap), 32'hC);
        chk("chg_pair", 32'(cnt), 32'h1);

        // Reset in the middle of a falling qualification
        repeat (5) run_cycle(4'b1100);
        do_reset(4'b1101);
        lat = -1;
        for (int k = 0; k < 20; k++) begin
            run_cycle(4'b1101);
            if (lat < 0 && obs_db[0]) lat = k;
        end
        chk("lat_after_rst", 32'(lat >= 11 && lat <= 14), 32'h1);

        // Random bouncing inputs; clears sometimes collide with events
        sw = 4'b1101;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < W; b++) begin
                if ($urandom_range(0, 11) == 0) sw[b] = ~sw[b];
            end
`ifdef SWITCH_DEBOUNCE_STICKY_EN
            sticky_clr = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) sticky_clr = sticky_clr | m_rise | m_fall;
`endif
            run_cycle(sw);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
